// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : main sequencing FSM of a multicycle RV32I datapath
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       fault,
  output logic       fault_cause
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [2:0] ALU_JUMP    = 3'b000;
  localparam logic [2:0] ALU_OPIMM   = 3'b001;
  localparam logic [2:0] ALU_ADD     = 3'b010;
  localparam logic [2:0] ALU_RTYPE   = 3'b100;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_EXEC_R  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_ALU_WB  = 4'd9,
    S_JAL     = 4'd10,
    S_FAULT   = 4'd11
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               cause;
  logic               waiting;
  logic               timeout;

  // A ready in the limit cycle still completes normally: timeout requires !mem_ready.
  always_comb begin
    waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == WAIT_LAST);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_FAULT;
        endcase
      end
      S_MEM_ADR: state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    state_nxt = S_MEM_WB;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_MEM_WB:  state_nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_EXEC_R:  state_nxt = S_ALU_WB;
      S_EXEC_I:  state_nxt = S_ALU_WB;
      S_ALU_WB:  state_nxt = S_FETCH;
      S_JAL:     state_nxt = S_ALU_WB;
      S_FAULT:   state_nxt = S_FAULT;
      default:   state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      cause    <= 1'b0;
    end else begin
      state <= state_nxt;
      // Any state change clears the counter, so each wait state starts from zero on entry.
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (waiting && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if ((state_nxt == S_FAULT) && (state != S_FAULT))
        cause <= timeout;
    end
  end

  // Outputs depend on the state register; only the completion strobes qualify with mem_ready.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_op      = ALU_JUMP;
    result_src  = RES_ALUOUT;
    retire      = 1'b0;
    fault       = 1'b0;
    fault_cause = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_RTYPE;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OPIMM;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_JUMP;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_FAULT: begin
        fault       = 1'b1;
        fault_cause = cause;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : directed checks of the multicycle control FSM
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Two instances: default timeout (15) and timeout disabled (0)
  logic       rst_n1 = 1'b0, rdy1 = 1'b0;
  logic [6:0] opc1 = 7'd0;
  logic       rst_n0 = 1'b0, rdy0 = 1'b0;
  logic [6:0] opc0 = 7'd0;

  logic       pcw1, irw1, adr1, mrd1, mwr1, rw1, ret1, flt1, fc1;
  logic [1:0] sa1, sb1, rs1;
  logic [2:0] op1;
  logic       pcw0, irw0, adr0, mrd0, mwr0, rw0, ret0, flt0, fc0;
  logic [1:0] sa0, sb0, rs0;
  logic [2:0] op0;

  multicycle_control #(.MEM_TIMEOUT(15)) dut1 (
    .clk(clk), .rst_n(rst_n1), .opcode(opc1), .mem_ready(rdy1),
    .pc_write(pcw1), .ir_write(irw1), .adr_src(adr1), .mem_read(mrd1),
    .mem_write(mwr1), .reg_write(rw1), .alu_src_a(sa1), .alu_src_b(sb1),
    .alu_op(op1), .result_src(rs1), .retire(ret1), .fault(flt1), .fault_cause(fc1)
  );

  multicycle_control #(.MEM_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .opcode(opc0), .mem_ready(rdy0),
    .pc_write(pcw0), .ir_write(irw0), .adr_src(adr0), .mem_read(mrd0),
    .mem_write(mwr0), .reg_write(rw0), .alu_src_a(sa0), .alu_src_b(sb0),
    .alu_op(op0), .result_src(rs0), .retire(ret0), .fault(flt0), .fault_cause(fc0)
  );

  // {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, a[1:0], b[1:0],
  //  alu_op[2:0], result_src[1:0], retire, fault, fault_cause}
  wire [17:0] obs1 = {pcw1, irw1, adr1, mrd1, mwr1, rw1, sa1, sb1, op1, rs1, ret1, flt1, fc1};
  wire [17:0] obs0 = {pcw0, irw0, adr0, mrd0, mwr0, rw0, sa0, sb0, op0, rs0, ret0, flt0, fc0};

  localparam logic [17:0] E_RESET   = 18'd0;
  localparam logic [17:0] E_FETCH_W = {6'b000100, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000};
  localparam logic [17:0] E_FETCH_R = {6'b110100, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000};
  localparam logic [17:0] E_DECODE  = {6'b000000, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000};
  localparam logic [17:0] E_MEMADR  = {6'b000000, 2'b10, 2'b01, 3'b010, 2'b00, 3'b000};
  localparam logic [17:0] E_MEMRD   = {6'b001100, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [17:0] E_MEMWB   = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 3'b100};
  localparam logic [17:0] E_MEMWR_W = {6'b001010, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [17:0] E_MEMWR_R = {6'b001010, 2'b00, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [17:0] E_EXECR   = {6'b000000, 2'b10, 2'b00, 3'b100, 2'b00, 3'b000};
  localparam logic [17:0] E_EXECI   = {6'b000000, 2'b10, 2'b01, 3'b001, 2'b00, 3'b000};
  localparam logic [17:0] E_ALUWB   = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [17:0] E_JAL     = {6'b100000, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000};
  localparam logic [17:0] E_FAULT0  = 18'b10;
  localparam logic [17:0] E_FAULT1  = 18'b11;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic [17:0] exp);
    #1;
    n_tests++;
    assert (obs1 === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs1, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [17:0] exp);
    #1;
    n_tests++;
    assert (obs0 === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs0, exp);
    end
  endtask

  task automatic restart1();
    rst_n1 = 1'b0; rdy1 = 1'b0;
    #1;
    rst_n1 = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state, then release: one RESET cycle before FETCH
    tick(); tick();
    chk1("reset_outputs", E_RESET);
    rst_n1 = 1'b1;
    chk1("release_reset_state", E_RESET);
    tick();
    chk1("fetch_after_reset", E_FETCH_W);

    // R-type, zero wait states
    opc1 = 7'b0110011; rdy1 = 1'b1;
    chk1("r_fetch", E_FETCH_R);
    tick(); chk1("r_decode", E_DECODE);
    tick(); chk1("r_exec", E_EXECR);
    tick(); chk1("r_alu_wb", E_ALUWB);
    tick(); chk1("r_back_fetch", E_FETCH_R);

    // lw with three wait cycles in MEM_RD
    opc1 = 7'b0000011;
    tick(); chk1("lw_decode", E_DECODE);
    tick(); chk1("lw_mem_adr", E_MEMADR);
    tick(); rdy1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("lw_mem_rd_wait", E_MEMRD);
      tick();
    end
    rdy1 = 1'b1;
    chk1("lw_mem_rd_done", E_MEMRD);
    tick(); chk1("lw_mem_wb", E_MEMWB);
    tick(); chk1("lw_back_fetch", E_FETCH_R);

    // jal, then an illegal opcode
    opc1 = 7'b1101111;
    tick(); chk1("jal_decode", E_DECODE);
    tick(); chk1("jal_jal", E_JAL);
    tick(); chk1("jal_alu_wb", E_ALUWB);
    tick(); chk1("ill_fetch", E_FETCH_R);
    opc1 = 7'b1111111;
    tick(); chk1("ill_decode", E_DECODE);
    for (int i = 0; i < 20; i++) begin
      tick();
      rdy1 = i[0];
      chk1("ill_fault_sticky", E_FAULT0);
    end

    // sw interrupted by reset while the write is pending
    restart1();
    opc1 = 7'b0100011; rdy1 = 1'b1;
    chk1("sw_fetch", E_FETCH_R);
    tick(); chk1("sw_decode", E_DECODE);
    tick(); chk1("sw_mem_adr", E_MEMADR);
    tick(); rdy1 = 1'b0;
    chk1("sw_mem_wr_wait", E_MEMWR_W);
    rst_n1 = 1'b0;
    chk1("reset_mid_write", E_RESET);
    rst_n1 = 1'b1;
    chk1("reset_release_mid", E_RESET);
    tick(); chk1("fetch_after_mid_reset", E_FETCH_W);

    // Fetch timeout: 15 waiting cycles, then FAULT with cause 1
    for (int i = 1; i < 15; i++) begin
      tick();
      chk1("fetch_waiting", E_FETCH_W);
    end
    tick(); chk1("fetch_timeout_fault", E_FAULT1);
    tick(); chk1("timeout_fault_sticky", E_FAULT1);

    // Ready arriving in the 15th waiting cycle completes normally
    restart1();
    opc1 = 7'b0010011;
    for (int i = 1; i < 15; i++) tick();
    rdy1 = 1'b1;
    chk1("fetch_ready_at_limit", E_FETCH_R);
    tick(); chk1("limit_decode", E_DECODE);
    tick(); chk1("i_exec", E_EXECI);
    tick(); chk1("i_alu_wb", E_ALUWB);

    // Timeout disabled: sw waits 100 cycles without faulting
    rst_n0 = 1'b1; opc0 = 7'b0100011;
    tick(); rdy0 = 1'b1;
    chk0("t0_fetch", E_FETCH_R);
    tick(); chk0("t0_decode", E_DECODE);
    tick(); chk0("t0_mem_adr", E_MEMADR);
    tick(); rdy0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk0("t0_mem_wr_wait", E_MEMWR_W);
      tick();
    end
    rdy0 = 1'b1;
    chk0("t0_mem_wr_retire", E_MEMWR_R);
    tick(); rdy0 = 1'b0;
    chk0("t0_back_fetch", E_FETCH_W);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
